// File: rtl/xbus_arbiter.sv
// Two-master xbus arbiter: round-robin grant with a bounded burst lock, then
// sequences address phase, read-latency wait and rdata/ack back to the owner.
module xbus_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        xbus_as,
  output logic        xbus_we,
  output logic [3:0]  xbus_be,
  output logic [31:0] xbus_addr,
  output logic [31:0] xbus_wdata,
  input  logic [31:0] xbus_rdata
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_gnt_q, last_gnt_d;
  logic          lock_q, lock_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic          locked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      lock_q     <= 1'b0;
      hold_q     <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      lock_q     <= lock_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Burst lock only holds while the previous owner still requests and has grants left.
  assign locked = lock_q && (hold_q < HW'(HOLD_MAX)) &&
                  (last_gnt_q ? m1_req : m0_req);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    lock_d     = lock_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          if (locked) begin
            owner_d = last_gnt_q;
            hold_d  = hold_q + HW'(1);
          end else begin
            owner_d = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
            hold_d  = HW'(1);
          end
          we_d    = owner_d ? m1_we    : m0_we;
          be_d    = owner_d ? m1_be    : m0_be;
          addr_d  = owner_d ? m1_addr  : m0_addr;
          wdata_d = owner_d ? m1_wdata : m0_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = CW'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // Read data lands straight in the owner's rdata so it is valid with ack.
          if (!we_q) begin
            if (owner_q) rdata1_d = xbus_rdata;
            else         rdata0_d = xbus_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        last_gnt_d = owner_q;
        lock_d     = owner_q ? m1_lock : m0_lock;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign xbus_as    = (state_q == S_ADDR) || (state_q == S_WAIT);
  assign xbus_we    = (state_q == S_ADDR) && we_q;
  assign xbus_be    = be_q;
  assign xbus_addr  = addr_q;
  assign xbus_wdata = wdata_q;
  assign m0_ack     = (state_q == S_RESP) && !owner_q;
  assign m1_ack     = (state_q == S_RESP) && owner_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: one RD_LAT=1 instance (a_*) and one
// RD_LAT=3 instance (b_*) driven by the same masters.
module tb_xbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 0, m0_lock = 0, m0_we = 0;
  logic [3:0]  m0_be = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic        m1_req = 0, m1_lock = 0, m1_we = 0;
  logic [3:0]  m1_be = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic [31:0] xbus_rdata = 0;

  logic        a_ack0, a_ack1, a_as, a_we;
  logic [31:0] a_rd0, a_rd1, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        b_ack0, b_ack1, b_as, b_we;
  logic [31:0] b_rd0, b_rd1, b_addr, b_wdata;
  logic [3:0]  b_be;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  xbus_arbiter #(.RD_LAT(1), .HOLD_MAX(4)) u_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(a_ack0), .m0_rdata(a_rd0),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(a_ack1), .m1_rdata(a_rd1),
    .xbus_as(a_as), .xbus_we(a_we), .xbus_be(a_be), .xbus_addr(a_addr),
    .xbus_wdata(a_wdata), .xbus_rdata(xbus_rdata)
  );

  xbus_arbiter #(.RD_LAT(3), .HOLD_MAX(4)) u_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(b_ack0), .m0_rdata(b_rd0),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(b_ack1), .m1_rdata(b_rd1),
    .xbus_as(b_as), .xbus_we(b_we), .xbus_be(b_be), .xbus_addr(b_addr),
    .xbus_wdata(b_wdata), .xbus_rdata(xbus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    next_cyc();
    next_cyc();
    rst = 1'b1;
  endtask

  // Per-cycle check of instance a: bit c of each mask is the expected value in cycle c.
  task automatic watch_a(input string tag, input int n,
                         input logic [7:0] eas, input logic [7:0] ewe,
                         input logic [7:0] eack0, input logic [7:0] eack1);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("%s.as%0d", tag, c),   32'(a_as),   32'(eas[c]));
      chk($sformatf("%s.we%0d", tag, c),   32'(a_we),   32'(ewe[c]));
      chk($sformatf("%s.ack0_%0d", tag, c), 32'(a_ack0), 32'(eack0[c]));
      chk($sformatf("%s.ack1_%0d", tag, c), 32'(a_ack1), 32'(eack1[c]));
      next_cyc();
    end
  endtask

  // Waits (bounded) for an ack on instance a; who=-1 on timeout, 2 if both acks.
  task automatic wait_ack(output int who, output int at);
    who = -1;
    at  = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_ack0 && a_ack1) who = 2;
      else if (a_ack0)      who = 0;
      else if (a_ack1)      who = 1;
      if (who != -1) at = cyc;
      next_cyc();
      if (who != -1) break;
    end
  endtask

  initial begin
    int who, at, prev_at;

    // Reset state
    #2;
    chk("rst.as", 32'(a_as), 0);
    chk("rst.ack0", 32'(a_ack0), 0);
    chk("rst.ack1", 32'(a_ack1), 0);
    chk("rst.addr", a_addr, 0);
    chk("rst.rd0", a_rd0, 0);
    chk("rst.b_as", 32'(b_as), 0);
    do_reset();

    // m0 read alone, RD_LAT=1
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000; m0_be = 4'hF;
    xbus_rdata = 32'hDEADBEEF;
    watch_a("rd0", 4, 8'b0110, 8'b0000, 8'b1000, 8'b0000);
    m0_req = 0;
    chk("rd0.rdata", a_rd0, 32'hDEADBEEF);
    chk("rd0.addr", a_addr, 32'h1000);

    // m1 read, then m1 write leaves m1_rdata untouched
    next_cyc();
    m1_req = 1; m1_we = 0; m1_addr = 32'h2004; xbus_rdata = 32'hCAFEF00D;
    wait_ack(who, at);
    m1_req = 0;
    chk("rd1.who", 32'(who), 1);
    chk("rd1.rdata", a_rd1, 32'hCAFEF00D);
    next_cyc();
    m1_req = 1; m1_we = 1; m1_addr = 32'h2000; m1_be = 4'b0011; m1_wdata = 32'h1234;
    xbus_rdata = 32'h99999999;
    watch_a("wr1", 4, 8'b0110, 8'b0010, 8'b0000, 8'b1000);
    m1_req = 0; m1_we = 0;
    chk("wr1.rdata_kept", a_rd1, 32'hCAFEF00D);
    chk("wr1.be", 32'(a_be), 32'h3);
    chk("wr1.addr", a_addr, 32'h2000);
    chk("wr1.wdata", a_wdata, 32'h1234);
    chk("wr1.rd0_kept", a_rd0, 32'hDEADBEEF);

    // Reset asserted during WAIT of an m0 read
    next_cyc();
    m0_req = 1; m0_addr = 32'h1000; xbus_rdata = 32'h5A5A5A5A;
    next_cyc();   // cycle 1: ADDR
    next_cyc();   // cycle 2: WAIT
    rst = 1'b0;
    #1;
    chk("arst.as", 32'(a_as), 0);
    chk("arst.addr", a_addr, 0);
    chk("arst.rd0", a_rd0, 0);
    chk("arst.ack0", 32'(a_ack0), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("arst.noack%0d", k), 32'(a_ack0 | a_ack1), 0);
      next_cyc();
    end
    rst = 1'b1;
    wait_ack(who, at);
    m0_req = 0;
    chk("arst.rereq_who", 32'(who), 0);
    chk("arst.rereq_rdata", a_rd0, 32'h5A5A5A5A);

    // Both request continuously, no lock: strict alternation, one access per 4 cycles
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    prev_at = -1;
    for (int i = 0; i < 8; i++) begin
      wait_ack(who, at);
      chk($sformatf("rr.who%0d", i), 32'(who), 32'(i % 2));
      if (i > 0) chk($sformatf("rr.gap%0d", i), 32'(at - prev_at), 4);
      prev_at = at;
    end
    m0_req = 0; m1_req = 0;

    // m1 locked burst vs pending m0: four m1 grants then m0
    do_reset();
    m1_req = 1; m1_lock = 1;
    next_cyc();
    m0_req = 1;
    for (int i = 0; i < 5; i++) begin
      wait_ack(who, at);
      chk($sformatf("lock.who%0d", i), 32'(who), (i < 4) ? 1 : 0);
    end
    m0_req = 0; m1_req = 0; m1_lock = 0;

    // RD_LAT=3 instance: rdata sampled in the last WAIT cycle
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h3000;
    for (int c = 0; c < 6; c++) begin
      xbus_rdata = 32'h100 + 32'(c);
      @(negedge clk);
      chk($sformatf("lat3.as%0d", c), 32'(b_as), (c >= 1 && c <= 4) ? 1 : 0);
      chk($sformatf("lat3.ack0_%0d", c), 32'(b_ack0), (c == 5) ? 1 : 0);
      chk($sformatf("lat3.ack1_%0d", c), 32'(b_ack1), 0);
      next_cyc();
    end
    m0_req = 0;
    chk("lat3.rdata", b_rd0, 32'h104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
